// File: rtl/multicycle_fsm.sv
// Main sequencing state machine for the multicycle ARM core.
// Walks the datapath through fetch/decode/execute/memory/writeback for
// data-processing, LDR/STR and B instructions over a shared memory, with a
// MemReady handshake that stretches fetch and memory-access cycles.
module multicycle_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               CondEx,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               InstrDone,
    output logic               Undef,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t state;
    state_t state_next;

    // Funct[2:1] carry no control meaning for this machine.
    logic unused_funct_bits;
    assign unused_funct_bits = ^Funct[2:1];

    // Compare/test ops (TST/TEQ/CMP/CMN) only update flags.
    logic is_compare;
    assign is_compare = (Funct[4:3] == 2'b10);

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state and output decode; everything is forced low during reset.
    always_comb begin
        state_next = FETCH;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        Branch     = 1'b0;
        InstrDone  = 1'b0;
        Undef      = 1'b0;

        case (state)
            FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = MemReady;
                NextPC     = MemReady;
                state_next = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (!CondEx) begin
                    state_next = FETCH;
                    InstrDone  = 1'b1;
                end else begin
                    case (Op)
                        2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                        2'b01:   state_next = MEMADR;
                        2'b10:   state_next = BRANCH;
                        default: begin
                            state_next = FETCH;
                            InstrDone  = 1'b1;
                            Undef      = 1'b1;
                        end
                    endcase
                end
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegW       = 1'b1;
                InstrDone  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemW       = 1'b1;
                InstrDone  = MemReady;
                state_next = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUOp      = 1'b1;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUOp      = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: begin
                RegW       = !is_compare;
                InstrDone  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                Branch     = 1'b1;
                InstrDone  = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        if (reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ResultSrc = 2'b00;
            ALUOp     = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            InstrDone = 1'b0;
            Undef     = 1'b0;
        end
    end

    assign State = reset ? '0 : state;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Directed bench for multicycle_fsm: each step drives inputs, queues the
// expected state and control vector, and compares them mid-cycle.
module tb_multicycle_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       CondEx;
    logic       MemReady;
    logic       IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW;
    logic       Branch, InstrDone, Undef;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned step_no = 0;

    // Expected per-cycle result: {state, control vector}.
    logic [17:0] sb_q[$];

    multicycle_fsm #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .CondEx(CondEx),
        .MemReady(MemReady), .IRWrite(IRWrite), .NextPC(NextPC),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .InstrDone(InstrDone), .Undef(Undef), .State(State)
    );

    always #5 clk = ~clk;

    // Control vector order:
    // IRWrite NextPC AdrSrc ALUSrcA ALUSrcB[2] ResultSrc[2] ALUOp RegW MemW Branch InstrDone Undef
    function automatic logic [13:0] model(input logic [3:0] st, input logic rst,
                                          input logic [1:0] op, input logic [5:0] fn,
                                          input logic cx, input logic mr);
        logic [13:0] v;
        v = '0;
        if (rst) return v;
        case (st)
            4'd0: v = {mr, mr, 1'b0, 1'b1, 2'b10, 2'b10, 6'b000000};
            4'd1: begin
                v = {2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 6'b000000};
                if (!cx)            v[1] = 1'b1;
                else if (op == 2'b11) begin v[1] = 1'b1; v[0] = 1'b1; end
            end
            4'd2: v = {2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 6'b000000};
            4'd3: v = {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 6'b000000};
            4'd4: v = {2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 6'b010010};
            4'd5: v = {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0, mr, 1'b0};
            4'd6: v = {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 6'b100000};
            4'd7: v = {2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 6'b100000};
            4'd8: v = {2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, fn[4:3] != 2'b10, 4'b0010};
            4'd9: v = {2'b00, 1'b0, 1'b0, 2'b01, 2'b10, 6'b000110};
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock cycle: drive, queue expectation, compare at the falling edge.
    task automatic step(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                        input logic cx, input logic mr, input logic [3:0] exp_state);
        logic [17:0] exp;
        logic [13:0] got;
        reset = rst; Op = op; Funct = fn; CondEx = cx; MemReady = mr;
        sb_q.push_back({exp_state, model(exp_state, rst, op, fn, cx, mr)});
        step_no++;
        @(negedge clk);
        exp = sb_q.pop_front();
        got = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, InstrDone, Undef};
        checks++;
        assert (State === exp[17:14]) else begin
            errors++;
            $error("FAIL state step %0d: got %0d expected %0d", step_no, State, exp[17:14]);
        end
        checks++;
        assert (got === exp[13:0]) else begin
            errors++;
            $error("FAIL ctrl step %0d state %0d: got %b expected %b",
                   step_no, exp[17:14], got, exp[13:0]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; Op = 2'b00; Funct = '0; CondEx = 1'b1; MemReady = 1'b1;
        #1;
        // Reset held three cycles
        step(1, 2'b00, 6'b000000, 1, 1, 4'd0);
        step(1, 2'b00, 6'b000000, 1, 1, 4'd0);
        step(1, 2'b00, 6'b000000, 1, 1, 4'd0);
        // ADD register: 0,1,6,8
        step(0, 2'b00, 6'b001000, 1, 1, 4'd0);
        step(0, 2'b00, 6'b001000, 1, 1, 4'd1);
        step(0, 2'b00, 6'b001000, 1, 1, 4'd6);
        step(0, 2'b00, 6'b001000, 1, 1, 4'd8);
        // CMP immediate: 0,1,7,8 with RegW low in ALUWB
        step(0, 2'b00, 6'b110101, 1, 1, 4'd0);
        step(0, 2'b00, 6'b110101, 1, 1, 4'd1);
        step(0, 2'b00, 6'b110101, 1, 1, 4'd7);
        step(0, 2'b00, 6'b110101, 1, 1, 4'd8);
        // LDR with two wait cycles in MEMREAD
        step(0, 2'b01, 6'b011001, 1, 1, 4'd0);
        step(0, 2'b01, 6'b011001, 1, 1, 4'd1);
        step(0, 2'b01, 6'b011001, 1, 1, 4'd2);
        step(0, 2'b01, 6'b011001, 1, 0, 4'd3);
        step(0, 2'b01, 6'b011001, 1, 0, 4'd3);
        step(0, 2'b01, 6'b011001, 1, 1, 4'd3);
        step(0, 2'b01, 6'b011001, 1, 1, 4'd4);
        // STR with one wait cycle in MEMWRITE
        step(0, 2'b01, 6'b011000, 1, 1, 4'd0);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd1);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd2);
        step(0, 2'b01, 6'b011000, 1, 0, 4'd5);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd5);
        // B skipped by condition: 0,1,0
        step(0, 2'b10, 6'b101000, 0, 1, 4'd0);
        step(0, 2'b10, 6'b101000, 0, 1, 4'd1);
        // Undefined Op=11: Undef pulse in DECODE
        step(0, 2'b11, 6'b000000, 1, 1, 4'd0);
        step(0, 2'b11, 6'b000000, 1, 1, 4'd1);
        // B taken: 0,1,9
        step(0, 2'b10, 6'b101000, 1, 1, 4'd0);
        step(0, 2'b10, 6'b101000, 1, 1, 4'd1);
        step(0, 2'b10, 6'b101000, 1, 1, 4'd9);
        // Fetch stall then a skipped DP op with Op=11-like priority check
        step(0, 2'b00, 6'b001000, 1, 0, 4'd0);
        step(0, 2'b11, 6'b001000, 0, 1, 4'd0);
        step(0, 2'b11, 6'b001000, 0, 1, 4'd1);
        // Reset asserted mid-MEMWRITE
        step(0, 2'b01, 6'b011000, 1, 1, 4'd0);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd1);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd2);
        step(0, 2'b01, 6'b011000, 1, 0, 4'd5);
        step(1, 2'b01, 6'b011000, 1, 0, 4'd0);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd0);
        step(0, 2'b01, 6'b011000, 1, 1, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_fsm.md
Name: multicycle_fsm

Overview:
- Main sequencing state machine for the multicycle ARM core; it replaces single-cycle control for a shared instruction/data memory.
- Steps the datapath through fetch, decode, execute, memory and writeback cycles for data-processing, LDR/STR and B instructions.
- Emits per-cycle mux selects and write enables. A memory ready handshake allows multi-cycle memory.
- Condition evaluation stays external; this block consumes only the resolved CondEx bit.

Parameters:
- STATE_W, 4, width of the exported state encoding (fixed; no other value is supported).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; returns FSM to FETCH
- Op  input  2  Instr[27:26] from the instruction register
- Funct  input  6  Instr[25:20] from the instruction register (I, cmd[3:0], S/L)
- CondEx  input  1  condition-pass result; valid during DECODE
- MemReady  input  1  memory completes the current access this cycle
- IRWrite  output  1  load instruction register
- NextPC  output  1  write PC with ResultSrc value
- AdrSrc  output  1  0 = PC address, 1 = ALU result register address
- ALUSrcA  output  1  0 = RD1, 1 = PC
- ALUSrcB  output  2  00 = RD2/shifted, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALU result direct
- ALUOp  output  1  1 = ALU function from Funct, 0 = add
- RegW  output  1  register file write enable
- MemW  output  1  memory write enable
- Branch  output  1  conditional-pass branch PC load
- InstrDone  output  1  one-cycle pulse on the final cycle of every instruction
- Undef  output  1  one-cycle pulse when an Op=11 instruction is discarded
- State  output  4  current state encoding, for debug and bench

Behaviour:
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10-15 are illegal and go to FETCH next cycle; all outputs are 0 in them.
- Outputs are Moore, except where MemReady or Funct gating is stated below. Any output not listed for a state is 0.
- Reset: the state is FETCH on the first cycle after reset. Reset mid-instruction abandons it, with no RegW/MemW/InstrDone pulse in the reset cycle (all outputs forced to 0 while reset=1).
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite and NextPC are asserted only when MemReady=1.
  - Holds in FETCH while MemReady=0; moves to DECODE on MemReady=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state:
  - CondEx=0 -> FETCH, with InstrDone=1 (the instruction is skipped).
  - Op=01 -> MEMADR.
  - Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI.
  - Op=10 -> BRANCH.
  - Op=11 -> FETCH, with InstrDone=1 and Undef=1.
  - CondEx=0 takes priority over Op decoding.
- MEMADR: ALUSrcA=0, ALUSrcB=01. Funct[0]=1 -> MEMREAD; else -> MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1, InstrDone=1; -> FETCH.
- MEMWRITE: AdrSrc=1, MemW=1 (held for every wait cycle).
  - Holds until MemReady=1; InstrDone=1 in that cycle; then -> FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1; -> ALUWB.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1; -> ALUWB.
- ALUWB: ResultSrc=00, InstrDone=1; -> FETCH.
  - RegW=1 except for compare/test ops, Funct[4:3]=2'b10 (TST/TEQ/CMP/CMN), which give RegW=0.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, InstrDone=1; -> FETCH.
- Latency with MemReady tied to 1:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles. STR: 4 cycles. B: 3 cycles.
  - Skipped or undefined instruction: 2 cycles.
- Each wait cycle adds 1. InstrDone fires exactly once per instruction.
- Op and Funct are sampled only in DECODE and MEMADR/ALUWB. The IR is stable there because IRWrite is confined to FETCH.

Test Plan:
- Reset held 3 cycles, then released with MemReady=1 -> State=0, all outputs 0 during reset; IRWrite=NextPC=1 in the first post-reset cycle.
- ADD reg (Op=00, Funct=6'b001000, CondEx=1, MemReady=1) -> State sequence 0,1,6,8,0; RegW=1 only in state 8; InstrDone once.
- CMP imm (Funct=6'b110101) -> sequence 0,1,7,8; RegW=0 in ALUWB, InstrDone=1.
- LDR (Op=01, Funct[0]=1) with MemReady=0 for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4; RegW=1 only in state 4; total 7 cycles.
- STR with MemReady low for 1 cycle -> MemW=1 for 2 consecutive cycles; InstrDone on the second; RegW never asserted.
- B with CondEx=0 -> 0,1,0 with Branch never asserted; Op=11 -> Undef=1 pulse in DECODE. Reset asserted mid-MEMWRITE -> MemW=0 that cycle, State=0 next.
